// File: rtl/aes_axi_pkg.sv
// Shared types and constants for the AES AXI4-Lite slave front end.
package aes_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_EXEC,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/aes_axi_lite_slave.sv
// AXI4-Lite slave that turns each accepted write/read into a one-cycle strobe
// on the AES register block. Write and read paths are independent FSMs.
module aes_axi_lite_slave
    import aes_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,

    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,

    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,

    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,

    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,

    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data
);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t              w_state_reg, w_state_next;
    logic                  aw_held_reg, w_held_reg;
    logic [ADDR_W-1:0]     awaddr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [DATA_W/8-1:0]   wstrb_reg;
    logic [1:0]            bresp_reg;
    logic                  aw_hs, w_hs, wr_ok;

    assign aw_hs = s_axi_awvalid && (w_state_reg == W_IDLE) && !aw_held_reg;
    assign w_hs  = s_axi_wvalid  && (w_state_reg == W_IDLE) && !w_held_reg;
    // Only full-word, word-aligned writes reach the register block.
    assign wr_ok = (wstrb_reg == '1) && (awaddr_reg[1:0] == 2'b00);

    always_comb begin
        w_state_next  = w_state_reg;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        wr_en         = 1'b0;
        unique case (w_state_reg)
            W_IDLE: begin
                s_axi_awready = !aw_held_reg;
                s_axi_wready  = !w_held_reg;
                if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs))
                    w_state_next = W_EXEC;
            end
            W_EXEC: begin
                wr_en        = wr_ok;
                w_state_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready)
                    w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_reg <= W_IDLE;
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            w_state_reg <= w_state_next;
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                awaddr_reg  <= s_axi_awaddr;
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= s_axi_wdata;
                wstrb_reg  <= s_axi_wstrb;
            end
            if (w_state_reg == W_EXEC) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign wr_addr     = awaddr_reg;
    assign wr_data     = wdata_reg;
    assign s_axi_bresp = bresp_reg;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t              r_state_reg, r_state_next;
    logic [ADDR_W-1:0]     araddr_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic [1:0]            rresp_reg;
    logic                  ar_hs, rd_aligned;

    assign ar_hs      = s_axi_arvalid && (r_state_reg == R_IDLE);
    assign rd_aligned = (araddr_reg[1:0] == 2'b00);

    always_comb begin
        r_state_next  = r_state_reg;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        rd_en         = 1'b0;
        unique case (r_state_reg)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid)
                    r_state_next = R_EXEC;
            end
            R_EXEC: begin
                rd_en        = 1'b1;
                r_state_next = R_RESP;
            end
            R_RESP: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready)
                    r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_reg <= R_IDLE;
            araddr_reg  <= '0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            r_state_reg <= r_state_next;
            if (ar_hs)
                araddr_reg <= s_axi_araddr;
            // Register-block data is combinational, so it is captured in the strobe cycle.
            if (r_state_reg == R_EXEC) begin
                rdata_reg <= rd_aligned ? rd_data : '0;
                rresp_reg <= rd_aligned ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign rd_addr     = araddr_reg;
    assign s_axi_rdata = rdata_reg;
    assign s_axi_rresp = rresp_reg;

endmodule

// File: tb/tb_aes_axi_lite_slave.sv
// Randomized self-checking bench for aes_axi_lite_slave against a transaction-level model.
module tb_aes_axi_lite_slave;
    import aes_axi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic        wr_en, rd_en;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;

    int checks = 0;
    int errors = 0;

    aes_axi_lite_slave #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // Cycle k is observed at the falling edge at time 10*k.
    function automatic int cyc_now();
        return int'($time / 10);
    endfunction

    // Record every strobe seen on the register-block side.
    int          wr_cyc_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rd_cyc_q[$];
    logic [31:0] rd_addr_q[$];

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_cyc_q.push_back(cyc_now());
            wr_addr_q.push_back(wr_addr);
            wr_data_q.push_back(wr_data);
        end
        if (rd_en === 1'b1) begin
            rd_cyc_q.push_back(cyc_now());
            rd_addr_q.push_back(rd_addr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // ---------------- channel drivers ----------------
    task automatic drive_aw(input logic [31:0] addr, input int dly, output int hs);
        hs = -1;
        repeat (dly) @(negedge clk);
        s_axi_awaddr  = addr;
        s_axi_awvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (s_axi_awready === 1'b1) begin
                hs = cyc_now();
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_axi_awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] data, input logic [3:0] strb, input int dly,
                           output int hs);
        hs = -1;
        repeat (dly) @(negedge clk);
        s_axi_wdata  = data;
        s_axi_wstrb  = strb;
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (s_axi_wready === 1'b1) begin
                hs = cyc_now();
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [31:0] addr, input int dly, output int hs);
        hs = -1;
        repeat (dly) @(negedge clk);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (s_axi_arready === 1'b1) begin
                hs = cyc_now();
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        s_axi_arvalid = 1'b0;
    endtask

    // ---------------- transaction-level write/read with model check ----------------
    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly,
                             input int b_hold, output int en_cyc);
        int aw_hs, w_hs, hmax, bcyc;
        logic exp_en;
        logic [1:0] exp_resp;
        en_cyc = -1;
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        exp_en   = (strb == 4'hF) && (addr[1:0] == 2'b00);
        exp_resp = exp_en ? RESP_OKAY : RESP_SLVERR;
        fork
            drive_aw(addr, aw_dly, aw_hs);
            drive_w(data, strb, w_dly, w_hs);
        join
        checks++;
        if (aw_hs < 0 || w_hs < 0) begin
            errors++;
            $display("FAIL write_handshake: aw_hs=%0d w_hs=%0d, required both accepted", aw_hs, w_hs);
            return;
        end
        hmax = (aw_hs > w_hs) ? aw_hs : w_hs;
        bcyc = -1;
        for (int i = 0; i < 20; i++) begin
            if (s_axi_bvalid === 1'b1) begin
                bcyc = cyc_now();
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (bcyc != hmax + 2) begin
            errors++;
            $display("FAIL write_bvalid_latency: bvalid in cycle %0d, required %0d", bcyc, hmax + 2);
            if (bcyc < 0) return;
        end
        for (int i = 0; i < b_hold; i++) begin
            checks++;
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== exp_resp || s_axi_awready !== 1'b0) begin
                errors++;
                $display("FAIL write_b_hold: bvalid=%b bresp=%b awready=%b, required 1/%b/0",
                         s_axi_bvalid, s_axi_bresp, s_axi_awready, exp_resp);
            end
            @(negedge clk);
        end
        checks++;
        if (s_axi_bresp !== exp_resp) begin
            errors++;
            $display("FAIL write_bresp: addr=%h strb=%h bresp=%b, required %b", addr, strb, s_axi_bresp, exp_resp);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        #1;
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
            errors++;
            $display("FAIL write_return_idle: bvalid=%b awready=%b wready=%b, required 0/1/1",
                     s_axi_bvalid, s_axi_awready, s_axi_wready);
        end
        checks++;
        if (exp_en) begin
            if (wr_cyc_q.size() != 1 || wr_cyc_q[0] != hmax + 1 || wr_addr_q[0] !== addr ||
                wr_data_q[0] !== data) begin
                errors++;
                $display("FAIL write_strobe: count=%0d cyc=%0d addr=%h data=%h, required 1/%0d/%h/%h",
                         wr_cyc_q.size(), (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1,
                         (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'hx,
                         (wr_data_q.size() > 0) ? wr_data_q[0] : 32'hx, hmax + 1, addr, data);
            end else begin
                en_cyc = wr_cyc_q[0];
            end
        end else if (wr_cyc_q.size() != 0) begin
            errors++;
            $display("FAIL write_no_strobe: addr=%h strb=%h strobes=%0d, required 0",
                     addr, strb, wr_cyc_q.size());
        end
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [31:0] rdat, input int ar_dly,
                            input int r_hold, output int en_cyc);
        int hs, rcyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        en_cyc = -1;
        rd_cyc_q.delete(); rd_addr_q.delete();
        exp_data = (addr[1:0] == 2'b00) ? rdat : 32'h0;
        exp_resp = (addr[1:0] == 2'b00) ? RESP_OKAY : RESP_SLVERR;
        rd_data  = rdat;
        drive_ar(addr, ar_dly, hs);
        checks++;
        if (hs < 0) begin
            errors++;
            $display("FAIL read_handshake: arready never seen, required acceptance");
            return;
        end
        rcyc = -1;
        for (int i = 0; i < 20; i++) begin
            if (s_axi_rvalid === 1'b1) begin
                rcyc = cyc_now();
                break;
            end
            @(negedge clk);
        end
        rd_data = ~rdat;
        checks++;
        if (rcyc != hs + 2) begin
            errors++;
            $display("FAIL read_rvalid_latency: rvalid in cycle %0d, required %0d", rcyc, hs + 2);
            if (rcyc < 0) return;
        end
        for (int i = 0; i < r_hold; i++) begin
            checks++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_data || s_axi_rresp !== exp_resp ||
                s_axi_arready !== 1'b0) begin
                errors++;
                $display("FAIL read_r_hold: rvalid=%b rdata=%h rresp=%b arready=%b, required 1/%h/%b/0",
                         s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_arready, exp_data, exp_resp);
            end
            @(negedge clk);
        end
        checks++;
        if (s_axi_rdata !== exp_data || s_axi_rresp !== exp_resp) begin
            errors++;
            $display("FAIL read_data: addr=%h rdata=%h rresp=%b, required %h/%b",
                     addr, s_axi_rdata, s_axi_rresp, exp_data, exp_resp);
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        #1;
        checks++;
        if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL read_return_idle: rvalid=%b arready=%b, required 0/1", s_axi_rvalid, s_axi_arready);
        end
        checks++;
        if (rd_cyc_q.size() != 1 || rd_cyc_q[0] != hs + 1 || rd_addr_q[0] !== addr) begin
            errors++;
            $display("FAIL read_strobe: count=%0d cyc=%0d addr=%h, required 1/%0d/%h",
                     rd_cyc_q.size(), (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1,
                     (rd_addr_q.size() > 0) ? rd_addr_q[0] : 32'hx, hs + 1, addr);
        end else begin
            en_cyc = rd_cyc_q[0];
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_readies: aw/w/ar ready=%b%b%b, required 111",
                     s_axi_awready, s_axi_wready, s_axi_arready);
        end
        checks++;
        if ({s_axi_bvalid, s_axi_rvalid, wr_en, rd_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valids: bvalid/rvalid/wr_en/rd_en=%b%b%b%b, required 0000",
                     s_axi_bvalid, s_axi_rvalid, wr_en, rd_en);
        end
        checks++;
        if (s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00 || s_axi_rdata !== 32'h0 ||
            wr_addr !== 32'h0 || wr_data !== 32'h0 || rd_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: bresp=%b rresp=%b rdata=%h wr_addr=%h wr_data=%h rd_addr=%h, required all 0",
                     s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_addr, wr_data, rd_addr);
        end
    endtask

    task automatic test_aligned_write();
        int c;
        write_txn(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, c);
    endtask

    task automatic test_w_before_aw();
        int c0, c;
        c0 = cyc_now();
        fork
            write_txn(32'h08, 32'h12345678, 4'hF, 3, 0, 1, c);
            begin
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clk);
                    checks++;
                    if (s_axi_wready !== 1'b0) begin
                        errors++;
                        $display("FAIL w_before_aw_wready: cycle +%0d wready=%b, required 0", k, s_axi_wready);
                    end
                end
            end
        join
        checks++;
        if (c != c0 + 4) begin
            errors++;
            $display("FAIL w_before_aw_latency: wr_en cycle %0d, required %0d", c, c0 + 4);
        end
    endtask

    task automatic test_slverr_writes();
        int c;
        write_txn(32'h00, 32'hCAFEF00D, 4'h3, 0, 0, 2, c);
        write_txn(32'h11, 32'h0BADBEEF, 4'hF, 1, 0, 0, c);
    endtask

    task automatic test_read();
        int c;
        read_txn(32'h04, 32'hA5A5A5A5, 0, 5, c);
        read_txn(32'h07, 32'h5A5A5A5A, 0, 1, c);
    endtask

    task automatic test_random_writes();
        logic [31:0] a;
        logic [3:0]  s;
        int c;
        for (int i = 0; i < 20; i++) begin
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
            s = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            write_txn(a, $urandom, s, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), c);
        end
    endtask

    task automatic test_random_reads();
        logic [31:0] a;
        int c;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            read_txn(a, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), c);
        end
    endtask

    task automatic test_concurrent();
        int wc, rc;
        fork
            write_txn(32'h20, 32'h1122_3344, 4'hF, 0, 0, 1, wc);
            read_txn(32'h2C, 32'h5566_7788, 0, 2, rc);
        join
        checks++;
        if (wc < 0 || wc != rc) begin
            errors++;
            $display("FAIL concurrent_strobes: wr_en cycle %0d rd_en cycle %0d, required equal", wc, rc);
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        logic [31:0] d;
        d = $urandom;
        wr_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        rd_cyc_q.delete(); rd_addr_q.delete();
        c0 = cyc_now();
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        s_axi_awaddr = 32'h40; s_axi_awvalid = 1'b1;
        s_axi_wdata = d; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h44; s_axi_arvalid = 1'b1;
        rd_data = $urandom;
        repeat (9) @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        repeat (3) @(negedge clk);
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        #1;
        checks++;
        if (wr_cyc_q.size() != 3 || wr_cyc_q[0] != c0 + 1 || wr_cyc_q[1] != c0 + 4 ||
            wr_cyc_q[2] != c0 + 7) begin
            errors++;
            $display("FAIL b2b_write_rate: %0d strobes first=%0d, required 3 at %0d,%0d,%0d",
                     wr_cyc_q.size(), (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, c0 + 1, c0 + 4, c0 + 7);
        end
        checks++;
        if (rd_cyc_q.size() != 3 || rd_cyc_q[0] != c0 + 1 || rd_cyc_q[1] != c0 + 4 ||
            rd_cyc_q[2] != c0 + 7) begin
            errors++;
            $display("FAIL b2b_read_rate: %0d strobes first=%0d, required 3 at %0d,%0d,%0d",
                     rd_cyc_q.size(), (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1, c0 + 1, c0 + 4, c0 + 7);
        end
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: bvalid=%b rvalid=%b, required 0/0", s_axi_bvalid, s_axi_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        wr_cyc_q.delete(); rd_cyc_q.delete();
        s_axi_awaddr = 32'h30; s_axi_awvalid = 1'b1;
        s_axi_wdata = $urandom; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        s_axi_araddr = 32'h34; s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        checks++;
        if (wr_en !== 1'b1 || rd_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_exec: wr_en=%b rd_en=%b before reset, required 1/1", wr_en, rd_en);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        wr_cyc_q.delete(); rd_cyc_q.delete();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({wr_en, rd_en, s_axi_bvalid, s_axi_rvalid} !== 4'b0000 ||
                {s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
                errors++;
                $display("FAIL reset_mid_after: cycle +%0d wr_en/rd_en/bvalid/rvalid=%b%b%b%b readies=%b%b%b, required 0000/111",
                         k, wr_en, rd_en, s_axi_bvalid, s_axi_rvalid,
                         s_axi_awready, s_axi_wready, s_axi_arready);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        rd_data = '0;
        test_reset();
        test_aligned_write();
        test_w_before_aw();
        test_slverr_writes();
        test_read();
        test_concurrent();
        test_random_writes();
        test_random_reads();
        test_back_to_back();
        test_reset_mid();
        test_aligned_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
